data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the core's MEM/WB stage and word-wide main memory.

---
 rtl/data_cache_pkg.sv | 32 +++
 rtl/data_cache_array.sv | 59 +++++
 rtl/data_cache.sv | 160 ++++++++++++++++
 tb/tb_data_cache.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared geometry, address-field types and FSM encoding for the direct-mapped
// write-back data cache.
package data_cache_pkg;

  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 4;
  localparam int TAG_LEN       = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
  localparam int SETS          = 1 << SET_ADDR_LEN;

  typedef logic [TAG_LEN-1:0]       tag_t;
  typedef logic [SET_ADDR_LEN-1:0]  set_t;
  typedef logic [LINE_ADDR_LEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  // Word address broken into its cache fields, MSB first.
  typedef struct packed {
    tag_t  tag;
    set_t  set;
    word_t word;
  } addr_fields_t;

  function automatic logic [31:0] beat_addr(input tag_t tag, input set_t set, input word_t word);
    return {tag, set, word, 2'b00};
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: combinational read port, byte-enable write
// port shared by stores and refill beats, and a line-install port.
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  set_t        rd_set,
  input  word_t       rd_word,
  output logic [31:0] rd_data,
  output tag_t        rd_tag,
  output logic        rd_valid,
  output logic        rd_dirty,
  input  logic        wr_en,
  input  set_t        wr_set,
  input  word_t       wr_word,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic        mark_dirty,
  input  logic        install,
  input  tag_t        install_tag
);

  logic [31:0]     data_mem [SETS][LINE_WORDS];
  tag_t            tag_mem  [SETS];
  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;

  assign rd_data  = data_mem[rd_set][rd_word];
  assign rd_tag   = tag_mem[rd_set];
  assign rd_valid = valid[rd_set];
  assign rd_dirty = dirty[rd_set];

  // NOTE: data and tag storage have no reset; only valid/dirty must be cleared,
  // and leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[wr_set][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (install) tag_mem[wr_set] <= install_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (install) begin
      valid[wr_set] <= 1'b1;
      dirty[wr_set] <= 1'b0;
    end else if (wr_en && mark_dirty) begin
      dirty[wr_set] <= 1'b1;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: hit path, miss FSM
// (write-back then refill), word-wide memory interface and perf counters.
module data_cache
  import data_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [3:0]  wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] access_cnt,
  output logic [31:0] miss_cnt
);

  state_t       state, state_next;
  word_t        cnt, cnt_next;
  tag_t         lat_tag;
  set_t         lat_set;
  addr_fields_t req;
  logic         request, is_store, hit, start_miss, last_beat;

  set_t         arr_set;
  word_t        arr_word;
  logic [31:0]  arr_rdata;
  tag_t         arr_tag;
  logic         arr_valid, arr_dirty;

  logic         wr_en, mark_dirty, install;
  set_t         wr_set;
  word_t        wr_word;
  logic [3:0]   wr_be;
  logic [31:0]  arr_wdata;

  logic         unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign req      = addr_fields_t'(addr[31:2]);
  assign is_store = |wr_req;
  assign request  = rd_req | is_store;

  // While a miss is outstanding the array is steered to the latched set and the beat counter.
  assign arr_set  = (state == IDLE) ? req.set  : lat_set;
  assign arr_word = (state == IDLE) ? req.word : cnt;

  assign hit        = (state == IDLE) && arr_valid && (arr_tag == req.tag);
  assign miss       = request && !hit;
  assign start_miss = (state == IDLE) && request && !hit;
  assign rd_data    = (request && hit) ? arr_rdata : '0;
  assign last_beat  = (cnt == word_t'(LINE_WORDS - 1));

  data_cache_array u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_set      (arr_set),
    .rd_word     (arr_word),
    .rd_data     (arr_rdata),
    .rd_tag      (arr_tag),
    .rd_valid    (arr_valid),
    .rd_dirty    (arr_dirty),
    .wr_en       (wr_en),
    .wr_set      (wr_set),
    .wr_word     (wr_word),
    .wr_be       (wr_be),
    .wr_data     (arr_wdata),
    .mark_dirty  (mark_dirty),
    .install     (install),
    .install_tag (lat_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_tag    <= '0;
      lat_set    <= '0;
      access_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (start_miss) begin
        lat_tag  <= req.tag;
        lat_set  <= req.set;
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (request && hit) access_cnt <= access_cnt + 32'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    mark_dirty = 1'b0;
    install    = 1'b0;
    wr_set     = req.set;
    wr_word    = req.word;
    wr_be      = wr_req;
    arr_wdata  = wr_data;

    case (state)
      IDLE: begin
        if (request && hit && is_store) begin
          wr_en      = 1'b1;
          mark_dirty = 1'b1;
        end else if (start_miss) begin
          cnt_next   = '0;
          state_next = (arr_valid && arr_dirty) ? WB : FILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = beat_addr(arr_tag, lat_set, cnt);
        mem_wdata = arr_rdata;
        if (mem_ack) begin
          cnt_next = cnt + word_t'(1);
          if (last_beat) begin
            cnt_next   = '0;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = beat_addr(lat_tag, lat_set, cnt);
        if (mem_ack) begin
          wr_en     = 1'b1;
          wr_set    = lat_set;
          wr_word   = cnt;
          wr_be     = 4'hF;
          arr_wdata = mem_rdata;
          cnt_next  = cnt + word_t'(1);
          if (last_beat) begin
            install    = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, multi-cycle corner
// sequences and randomized traffic against a line-level cache/memory model.
module tb_data_cache;
  import data_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [3:0]  wr_req;
  logic [31:0] addr, wr_data, rd_data;
  logic        miss, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, access_cnt, miss_cnt;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .access_cnt(access_cnt),
    .miss_cnt(miss_cnt)
  );

  localparam int MEM_WORDS = 2048;
  localparam int BUDGET    = 500;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic        rd;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rdata;
    int          cyc;
    int          wr_b;
    int          rd_b;
    int          mcnt;
    int          acnt;
  } vec_t;

  logic [31:0] phys [MEM_WORDS];
  logic [31:0] gold [MEM_WORDS];
  beat_t       beats[$];
  int          ack_delay, wait_cnt, stab_viol;
  logic        waiting, hold_we;
  logic [31:0] hold_addr;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Line-level model of cache contents.
  logic        m_valid [SETS];
  logic        m_dirty [SETS];
  tag_t        m_tag   [SETS];
  int          exp_miss_cnt, exp_access_cnt;
  int          e_wr, e_rd;
  logic [31:0] e_vbase, e_fbase, e_rdata;
  logic [31:0] e_wb [LINE_WORDS];

  function automatic int widx(input logic [31:0] a);
    return int'(a[12:2]);
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0101);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks each beat after ack_delay waiting cycles.
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      mem_ack  = 1'b0;
      waiting  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (waiting && (mem_addr !== hold_addr || mem_we !== hold_we)) stab_viol++;
      if (!waiting) begin
        waiting   = 1'b1;
        hold_addr = mem_addr;
        hold_we   = mem_we;
        wait_cnt  = 0;
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        waiting = 1'b0;
        b.we = mem_we;
        b.a  = mem_addr;
        if (mem_we) begin
          b.d = mem_wdata;
          phys[widx(mem_addr)] = mem_wdata;
        end else begin
          b.d = phys[widx(mem_addr)];
          mem_rdata = phys[widx(mem_addr)];
        end
        beats.push_back(b);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      waiting  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = '0;
    end
    for (int i = 0; i < MEM_WORDS; i++) gold[i] = phys[i];
    exp_miss_cnt   = 0;
    exp_access_cnt = 0;
  endtask

  // Predicts memory traffic and load data for one access, then applies it.
  task automatic model_apply(input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    int   s;
    tag_t t;
    logic [31:0] old;
    s = int'(a[8:5]);
    t = a[31:9];
    e_wr = 0;
    e_rd = 0;
    e_fbase = {a[31:5], 5'b0};
    e_vbase = '0;
    if (!(m_valid[s] && m_tag[s] == t)) begin
      exp_miss_cnt++;
      e_rd = LINE_WORDS;
      if (m_valid[s] && m_dirty[s]) begin
        e_wr    = LINE_WORDS;
        e_vbase = {m_tag[s], a[8:5], 5'b0};
        for (int i = 0; i < LINE_WORDS; i++) e_wb[i] = gold[widx(e_vbase + 32'(4 * i))];
      end
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
    exp_access_cnt++;
    e_rdata = gold[widx(a)];
    if (be != 4'h0) begin
      old = gold[widx(a)];
      for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
      gold[widx(a)] = old;
      m_dirty[s] = 1'b1;
    end
  endtask

  // Drives one request at a negedge, holds it until served, returns at the next negedge.
  task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, output int cycles, output logic [31:0] rdat);
    rd_req  = rd;
    wr_req  = be;
    addr    = a;
    wr_data = wd;
    cycles  = 0;
    #1;
    while (miss && cycles < BUDGET) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (miss) check("access timeout", 32'd1, 32'd0);
    rdat = rd_data;
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 4'h0;
  endtask

  task automatic check_beats(input string name);
    int errs;
    errs = 0;
    check({name, " beat count"}, 32'(beats.size()), 32'(e_wr + e_rd));
    foreach (beats[i]) begin
      if (i < e_wr) begin
        if (!beats[i].we || beats[i].a !== e_vbase + 32'(4 * i) || beats[i].d !== e_wb[i]) errs++;
      end else begin
        if (beats[i].we || beats[i].a !== e_fbase + 32'(4 * (i - e_wr))) errs++;
      end
    end
    check({name, " beat sequence"}, 32'(errs), 32'd0);
  endtask

  task automatic run_checked(input string name, input logic rd, input logic [3:0] be,
                             input logic [31:0] a, input logic [31:0] wd);
    int cyc, exp_cyc;
    logic [31:0] rdat;
    beats.delete();
    model_apply(be, a, wd);
    access(rd, be, a, wd, cyc, rdat);
    exp_cyc = (e_rd == 0) ? 0 : 1 + (e_wr + e_rd) * (ack_delay + 1);
    if (rd && be == 4'h0) check({name, " rd_data"}, rdat, e_rdata);
    check({name, " miss cycles"}, 32'(cyc), 32'(exp_cyc));
    check_beats(name);
  endtask

  vec_t        vt [5];
  logic [31:0] w108;

  initial begin
    int cyc, nwr, nrd;
    logic [31:0] rdat, a;
    logic [3:0]  be;

    rst_n = 1'b0; rd_req = 1'b0; wr_req = 4'h0; addr = '0; wr_data = '0;
    mem_ack = 1'b0; mem_rdata = '0; ack_delay = 0; stab_viol = 0;
    waiting = 1'b0; wait_cnt = 0; hold_addr = '0; hold_we = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) phys[i] = init_word(32'(i * 4));
    model_reset();

    #1;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset miss", 32'(miss), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    check("reset miss_cnt", miss_cnt, 32'd0);
    check("reset access_cnt", access_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, immediate acks.
    w108  = init_word(32'h108);
    vt[0] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, init_word(32'h100), 9, 0, 8, 1, 1};
    vt[1] = '{1'b1, 4'h0, 32'h0000_0104, 32'h0, 1'b1, init_word(32'h104), 0, 0, 0, 1, 2};
    vt[2] = '{1'b0, 4'h3, 32'h0000_0108, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 0, 0, 1, 3};
    vt[3] = '{1'b1, 4'h0, 32'h0000_0108, 32'h0, 1'b1, {w108[31:16], 16'hBEEF}, 0, 0, 0, 1, 4};
    vt[4] = '{1'b1, 4'h0, 32'h0000_0300, 32'h0, 1'b1, init_word(32'h300), 17, 8, 8, 2, 5};
    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      beats.delete();
      model_apply(vt[v].be, vt[v].a, vt[v].wd);
      access(vt[v].rd, vt[v].be, vt[v].a, vt[v].wd, cyc, rdat);
      nwr = 0;
      nrd = 0;
      foreach (beats[i]) if (beats[i].we) nwr++; else nrd++;
      if (vt[v].chk_rd) check({nm, " rd_data"}, rdat, vt[v].rdata);
      check({nm, " miss cycles"}, 32'(cyc), 32'(vt[v].cyc));
      check({nm, " write beats"}, 32'(nwr), 32'(vt[v].wr_b));
      check({nm, " read beats"}, 32'(nrd), 32'(vt[v].rd_b));
      check({nm, " miss_cnt"}, miss_cnt, 32'(vt[v].mcnt));
      check({nm, " access_cnt"}, access_cnt, 32'(vt[v].acnt));
      check_beats(nm);
    end
    #1;
    check("idle rd_data", rd_data, 32'd0);
    check("idle mem_req", 32'(mem_req), 32'd0);

    // Slow memory, request dropped mid-refill: line must still be installed.
    ack_delay = 5;
    stab_viol = 0;
    beats.delete();
    model_apply(4'h0, 32'h0000_0460, 32'h0);
    exp_access_cnt--;
    rd_req = 1'b1;
    addr   = 32'h0000_0460;
    repeat (12) @(negedge clk);
    rd_req = 1'b0;
    #1;
    check("drop miss low", 32'(miss), 32'd0);
    cyc = 0;
    while (!(beats.size() >= LINE_WORDS && !mem_req) && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_beats("drop fill");
    check("drop addr stable", 32'(stab_viol), 32'd0);
    check("drop miss_cnt", miss_cnt, 32'(exp_miss_cnt));
    @(negedge clk);
    run_checked("drop reload", 1'b1, 4'h0, 32'h0000_0464, 32'h0);
    check("drop access_cnt", access_cnt, 32'(exp_access_cnt));

    // Reset in the middle of a write-back.
    ack_delay = 2;
    run_checked("dirty store", 1'b0, 4'hF, 32'h0000_0300, 32'h1234_5678);
    beats.delete();
    rd_req = 1'b1;
    addr   = 32'h0000_0500;
    cyc = 0;
    while (beats.size() < 3 && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("wb reached beat 3", 32'(beats.size() >= 3), 32'd1);
    rst_n  = 1'b0;
    rd_req = 1'b0;
    #1;
    check("mid-wb reset mem_req", 32'(mem_req), 32'd0);
    check("mid-wb reset mem_we", 32'(mem_we), 32'd0);
    check("mid-wb reset miss_cnt", miss_cnt, 32'd0);
    check("mid-wb reset access_cnt", access_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_checked("post-reset load", 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("post-reset miss_cnt", miss_cnt, 32'd1);

    // Randomized loads/stores over an 8 KiB window (heavy set conflicts).
    for (int n = 0; n < 250; n++) begin
      ack_delay = int'($urandom_range(0, 2));
      a = ($urandom() & 32'h0000_1FFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) be = 4'h0;
      else be = 4'($urandom_range(1, 15));
      run_checked($sformatf("rand%0d", n), (be == 4'h0), be, a, $urandom());
    end
    check("final miss_cnt", miss_cnt, 32'(exp_miss_cnt));
    check("final access_cnt", access_cnt, 32'(exp_access_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
